// File: rtl/jedro_1_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port bytewrite data RAM between the core
// load/store path (m0) and a secondary master (m1), with a fixed 1-cycle response path.
module jedro_1_dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  // master 0
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,
  // master 1
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,
  // RAM side
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  // Handshake: a master holds req (payload may change) until gnt is seen in the same
  // cycle; its response (rvalid, plus rdata/err) follows exactly one cycle later.

  logic last_m1_q, last_m1_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_owner_q, rsp_owner_d;
  logic rsp_read_q, rsp_read_d;
  logic rsp_err_q, rsp_err_d;

  logic                  gnt0, gnt1, any_gnt, be_legal, sel_we;
  logic [3:0]            sel_be;
  logic [ADDR_WIDTH-3:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, rsp_rdata;
  logic                  unused_addr_lsbs;

  // Word-addressed RAM: the byte offset carries no meaning here.
  assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (m0_req_i && m1_req_i) begin
      if (last_m1_q) gnt0 = 1'b1;
      else           gnt1 = 1'b1;
    end else begin
      gnt0 = m0_req_i;
      gnt1 = m1_req_i;
    end
    any_gnt = gnt0 | gnt1;

    sel_we    = gnt1 ? m1_we_i                     : m0_we_i;
    sel_be    = gnt1 ? m1_be_i                     : m0_be_i;
    sel_addr  = gnt1 ? m1_addr_i[ADDR_WIDTH-1:2]   : m0_addr_i[ADDR_WIDTH-1:2];
    sel_wdata = gnt1 ? m1_wdata_i                  : m0_wdata_i;

    // Only naturally aligned byte, halfword and word lane groups reach the RAM.
    case (sel_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase

    ram_en_o    = any_gnt & be_legal;
    ram_we_o    = (any_gnt && be_legal && sel_we) ? sel_be : 4'b0000;
    ram_addr_o  = sel_addr;
    ram_wdata_o = sel_wdata;

    last_m1_d   = any_gnt ? gnt1 : last_m1_q;
    rsp_valid_d = any_gnt;
    rsp_owner_d = gnt1;
    rsp_read_d  = any_gnt & be_legal & ~sel_we;
    rsp_err_d   = any_gnt & ~be_legal;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_m1_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_m1_q   <= last_m1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_read_q  <= rsp_read_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Write and error responses return zero data; the non-owner sees an idle port.
  always_comb begin
    rsp_rdata   = rsp_read_q ? ram_rdata_i : '0;
    m0_gnt_o    = gnt0;
    m1_gnt_o    = gnt1;
    m0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
    m1_rvalid_o = rsp_valid_q &  rsp_owner_q;
    m0_rdata_o  = m0_rvalid_o ? rsp_rdata : '0;
    m1_rdata_o  = m1_rvalid_o ? rsp_rdata : '0;
    m0_err_o    = m0_rvalid_o & rsp_err_q;
    m1_err_o    = m1_rvalid_o & rsp_err_q;
  end

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// Bench for jedro_1_dmem_arbiter: behavioural RAM, a reference model of arbitration and
// response rules, directed scenarios followed by randomized traffic.
module tb_jedro_1_dmem_arbiter;

  localparam int RSP_W = 68;  // {v0, e0, d0[31:0], v1, e1, d1[31:0]}

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_v[2];
  logic        we_v[2];
  logic [3:0]  be_v[2];
  logic [31:0] addr_v[2];
  logic [31:0] wdata_v[2];

  logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [29:0] ram_addr_o;
  logic [31:0] ram_wdata_o, ram_rdata;

  // clock / reset
  always #5 clk = ~clk;

  jedro_1_dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .m0_req_i(req_v[0]), .m0_addr_i(addr_v[0]), .m0_we_i(we_v[0]), .m0_be_i(be_v[0]),
    .m0_wdata_i(wdata_v[0]), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(req_v[1]), .m1_addr_i(addr_v[1]), .m1_we_i(we_v[1]), .m1_be_i(be_v[1]),
    .m1_wdata_i(wdata_v[1]), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  // behavioural bytewrite RAM (16 words), loaded once during the first reset
  logic [31:0] tb_ram[16];
  logic [31:0] init_val[16];
  logic        ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16; i++) tb_ram[i] <= init_val[i];
      ram_loaded <= 1'b1;
    end else if (ram_en_o) begin
      ram_rdata <= tb_ram[ram_addr_o[3:0]];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) tb_ram[ram_addr_o[3:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [RSP_W-1:0] exp_q[$];
  logic [31:0]      ref_mem[16];
  int               last_gnt;
  logic             gseen[2];

  task automatic check_eq(input string tag, input logic [RSP_W-1:0] act,
                          input logic [RSP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] be);
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  always @(negedge clk) begin
    logic [RSP_W-1:0] act_rsp, nxt;
    logic [31:0]      exp_d;
    logic             legal;
    int               w;
    act_rsp = {m0_rvalid_o, m0_err_o, m0_rdata_o, m1_rvalid_o, m1_err_o, m1_rdata_o};
    gseen[0] = m0_gnt_o;
    gseen[1] = m1_gnt_o;
    if (!rstn_i) begin
      check_eq("rst_rsp", act_rsp, '0);
      check_eq("rst_gnt", {m1_gnt_o, m0_gnt_o}, '0);
      check_eq("rst_ram", {ram_en_o, ram_we_o}, '0);
      exp_q.delete();
      exp_q.push_back('0);
      last_gnt = 1;
    end else begin
      if (exp_q.size() == 0) check_eq("rsp_q_empty", 1, 0);
      else check_eq("rsp", act_rsp, exp_q.pop_front());
      // the master not granted most recently wins a contention
      if (req_v[0] && req_v[1]) w = 1 - last_gnt;
      else if (req_v[0])        w = 0;
      else if (req_v[1])        w = 1;
      else                      w = -1;
      check_eq("gnt", {m1_gnt_o, m0_gnt_o}, (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10));
      nxt = '0;
      if (w >= 0) begin
        last_gnt = w;
        legal = is_legal(be_v[w]);
        check_eq("ram_en", ram_en_o, legal);
        check_eq("ram_we", ram_we_o, (legal && we_v[w]) ? be_v[w] : 4'b0000);
        check_eq("ram_addr", ram_addr_o, addr_v[w][31:2]);
        check_eq("ram_wdata", ram_wdata_o, wdata_v[w]);
        exp_d = (legal && !we_v[w]) ? ref_mem[addr_v[w][5:2]] : 32'h0;
        if (legal && we_v[w])
          for (int b = 0; b < 4; b++)
            if (be_v[w][b]) ref_mem[addr_v[w][5:2]][8*b +: 8] = wdata_v[w][8*b +: 8];
        if (w == 0) nxt = {1'b1, !legal, exp_d, 34'h0};
        else        nxt = {34'h0, 1'b1, !legal, exp_d};
      end else begin
        check_eq("idle_ram", {ram_en_o, ram_we_o}, '0);
      end
      exp_q.push_back(nxt);
    end
  end

  // driver tasks
  task automatic set_master(input int m, input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    req_v[m] = req; we_v[m] = we; be_v[m] = be; addr_v[m] = addr; wdata_v[m] = wdata;
  endtask

  // present a request at the next cycle and wait (bounded) for its grant
  task automatic issue(input int m, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    set_master(m, 1'b1, we, be, addr, wdata);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = gseen[m];
    end
    check_eq("gnt_wait", got, 1'b1);
  endtask

  task automatic idle_all();
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
  endtask

  function automatic logic [3:0] rand_be();
    logic [3:0] legal_set[7];
    legal_set = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    if ($urandom_range(0, 3) != 0) return legal_set[$urandom_range(0, 6)];
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic rand_payload(input int m);
    set_master(m, 1'b1, 1'($urandom_range(0, 1)), rand_be(), 32'($urandom_range(0, 63)),
               $urandom);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      init_val[i] = $urandom;
      if (i == 1) init_val[i] = 32'hFFFF_FFFF;
      if (i == 2) init_val[i] = 32'h0;
      ref_mem[i] = init_val[i];
    end
    for (int m = 0; m < 2; m++) set_master(m, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    rstn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn_i = 1'b1;

    // both masters contend for 6 cycles: expect alternation starting at m0
    @(posedge clk); #1;
    set_master(0, 1'b1, 1'b0, 4'b1111, 32'h4, 32'h0);
    set_master(1, 1'b1, 1'b0, 4'b1111, 32'h8, 32'h0);
    repeat (6) @(posedge clk);
    #1 req_v[0] = 1'b0; req_v[1] = 1'b0;

    // m0 read of the preloaded word, m1 byte write then m0 read-back
    issue(0, 1'b0, 4'b1111, 32'h4, 32'h0);
    idle_all();
    issue(1, 1'b1, 4'b0001, 32'h8, 32'h0000_000F);
    idle_all();
    issue(0, 1'b0, 4'b1111, 32'h8, 32'h0);
    // illegal enables, including the empty pattern
    issue(0, 1'b1, 4'b0101, 32'h8, 32'hDEAD_BEEF);
    issue(1, 1'b0, 4'b0000, 32'hC, 32'h0);
    issue(1, 1'b1, 4'b0110, 32'h8, 32'h1234_5678);
    idle_all();
    issue(0, 1'b0, 4'b1111, 32'h8, 32'h0);
    idle_all();
    // m1 back-to-back reads
    issue(1, 1'b0, 4'b1111, 32'h0, 32'h0);
    issue(1, 1'b0, 4'b1111, 32'h4, 32'h0);
    issue(1, 1'b0, 4'b1111, 32'h8, 32'h0);
    issue(1, 1'b0, 4'b1111, 32'hC, 32'h0);
    idle_all();
    // make m0 the last granted, then reset while its read response is pending
    issue(1, 1'b0, 4'b1111, 32'h0, 32'h0);
    req_v[1] = 1'b0;
    issue(0, 1'b0, 4'b1111, 32'h4, 32'h0);
    #1 rstn_i = 1'b0;
    req_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_master(0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0);
    set_master(1, 1'b1, 1'b0, 4'b1111, 32'h14, 32'h0);
    repeat (3) @(posedge clk);
    #1 req_v[0] = 1'b0; req_v[1] = 1'b0;

    // randomized traffic: hold until granted, occasional payload change or drop
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (req_v[m] && !gseen[m]) begin
          case ($urandom_range(0, 7))
            0:       req_v[m] = 1'b0;
            1:       rand_payload(m);
            default: ;
          endcase
        end else if ($urandom_range(0, 2) != 0) begin
          rand_payload(m);
        end else begin
          req_v[m] = 1'b0;
        end
      end
    end
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) check_eq("ram_word", tb_ram[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
